// File: rtl/branch_predictor_if.sv
// Fetch/decode bus of the branch predictor: fetch lookup, decode-stage training and statistics.
interface branch_predictor_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic [DATA_WIDTH-1:0] pc_f;
   logic                  hit_f;
   logic                  pred_taken_f;
   logic [DATA_WIDTH-1:0] next_pc_f;
   logic                  upd_en;
   logic [DATA_WIDTH-1:0] upd_pc;
   logic                  upd_taken;
   logic [DATA_WIDTH-1:0] upd_target;
   logic                  upd_pred_taken;
   logic [DATA_WIDTH-1:0] upd_pred_target;
   logic                  flush_all;
   logic                  mispredict;
   logic [CNT_WIDTH-1:0]  branch_cnt;
   logic [CNT_WIDTH-1:0]  mispredict_cnt;

   modport master (
      output pc_f, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush_all,
      input  hit_f, pred_taken_f, next_pc_f, mispredict, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  pc_f, upd_en, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target, flush_all,
      output hit_f, pred_taken_f, next_pc_f, mispredict, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// decode-stage training, and saturating branch/mispredict statistics.
module branch_predictor #(
   parameter int DATA_WIDTH   = 32,
   parameter int ENTRIES      = 16,
   parameter int PREDICT_MODE = 1,
   parameter int CNT_WIDTH    = 16
) (
   input logic               clk,
   input logic               rst,
   branch_predictor_if.slave bus
);
   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = DATA_WIDTH - IDX - 2;
   localparam int TGT_W = DATA_WIDTH - 2;

   function automatic logic [1:0] ctrInc(input logic [1:0] c);
      return (c == 2'b11) ? 2'b11 : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctrDec(input logic [1:0] c);
      return (c == 2'b00) ? 2'b00 : c - 2'b01;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] cntSat(input logic [CNT_WIDTH-1:0] c, input logic inc);
      return (inc && (c != {CNT_WIDTH{1'b1}})) ? c + CNT_WIDTH'(1) : c;
   endfunction

   logic                  entryValid_r  [ENTRIES];
   logic [TAG_W-1:0]      entryTag_r    [ENTRIES];
   logic [TGT_W-1:0]      entryTarget_r [ENTRIES];
   logic [1:0]            entryCtr_r    [ENTRIES];
   logic [CNT_WIDTH-1:0]  branchCnt_r;
   logic [CNT_WIDTH-1:0]  mispredictCnt_r;

   logic [IDX-1:0]        lookupIdx_s;
   logic [TAG_W-1:0]      lookupTag_s;
   logic                  lookupHit_s;
   logic                  predTaken_s;
   logic [DATA_WIDTH-1:0] nextPc_s;
   logic [IDX-1:0]        updIdx_s;
   logic [TAG_W-1:0]      updTag_s;
   logic                  updHit_s;
   logic                  mispredict_s;
   logic                  unusedBits_s;

   assign lookupIdx_s  = bus.pc_f[IDX+1:2];
   assign lookupTag_s  = bus.pc_f[DATA_WIDTH-1:IDX+2];
   assign updIdx_s     = bus.upd_pc[IDX+1:2];
   assign updTag_s     = bus.upd_pc[DATA_WIDTH-1:IDX+2];
   // Word alignment bits never take part in indexing or tagging.
   assign unusedBits_s = ^{bus.pc_f[1:0], bus.upd_pc[1:0]};

   // Fetch-side lookup: hit, direction and next fetch PC from the pre-update table.
   always_comb begin
      lookupHit_s = 1'b0;
      predTaken_s = 1'b0;
      nextPc_s    = bus.pc_f + DATA_WIDTH'(4);
      if (PREDICT_MODE == 1) begin
         lookupHit_s = entryValid_r[lookupIdx_s] && (entryTag_r[lookupIdx_s] == lookupTag_s);
      end else begin
         lookupHit_s = 1'b0;
      end
      predTaken_s = lookupHit_s && entryCtr_r[lookupIdx_s][1];
      if (predTaken_s) begin
         nextPc_s = {entryTarget_r[lookupIdx_s], 2'b00};
      end else begin
         nextPc_s = bus.pc_f + DATA_WIDTH'(4);
      end
   end

   // Decode-side resolution: entry match and misprediction detection.
   always_comb begin
      updHit_s     = entryValid_r[updIdx_s] && (entryTag_r[updIdx_s] == updTag_s);
      mispredict_s = 1'b0;
      if (bus.upd_en) begin
         mispredict_s = (bus.upd_taken != bus.upd_pred_taken) ||
                        (bus.upd_taken && (bus.upd_pred_target != bus.upd_target));
      end else begin
         mispredict_s = 1'b0;
      end
   end

   // BTB training; a flush in the same cycle suppresses allocation and training.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entryValid_r[i]  <= 1'b0;
            entryTag_r[i]    <= {TAG_W{1'b0}};
            entryTarget_r[i] <= {TGT_W{1'b0}};
            entryCtr_r[i]    <= 2'b01;
         end
      end else if (bus.flush_all) begin
         for (int i = 0; i < ENTRIES; i++) begin
            entryValid_r[i] <= 1'b0;
         end
      end else if (bus.upd_en && (PREDICT_MODE == 1)) begin
         if (updHit_s) begin
            if (bus.upd_taken) begin
               entryCtr_r[updIdx_s]    <= ctrInc(entryCtr_r[updIdx_s]);
               entryTarget_r[updIdx_s] <= bus.upd_target[DATA_WIDTH-1:2];
            end else begin
               entryCtr_r[updIdx_s]    <= ctrDec(entryCtr_r[updIdx_s]);
            end
         end else if (bus.upd_taken) begin
            entryValid_r[updIdx_s]  <= 1'b1;
            entryTag_r[updIdx_s]    <= updTag_s;
            entryTarget_r[updIdx_s] <= bus.upd_target[DATA_WIDTH-1:2];
            entryCtr_r[updIdx_s]    <= 2'b10;
         end
      end
   end

   // Statistics count regardless of flush or prediction mode, saturating at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         branchCnt_r     <= {CNT_WIDTH{1'b0}};
         mispredictCnt_r <= {CNT_WIDTH{1'b0}};
      end else begin
         branchCnt_r     <= cntSat(branchCnt_r, bus.upd_en);
         mispredictCnt_r <= cntSat(mispredictCnt_r, mispredict_s);
      end
   end

   assign bus.hit_f          = lookupHit_s;
   assign bus.pred_taken_f   = predTaken_s;
   assign bus.next_pc_f      = nextPc_s;
   assign bus.mispredict     = mispredict_s;
   assign bus.branch_cnt     = branchCnt_r;
   assign bus.mispredict_cnt = mispredictCnt_r;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench: default predictor, a 4-bit-counter variant and a static variant share stimulus.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   branch_predictor_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) busA ();
   branch_predictor_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  busB ();
   branch_predictor_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) busC ();

   branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .PREDICT_MODE(1), .CNT_WIDTH(16))
      dutA (.clk(clk), .rst(rst), .bus(busA));
   branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .PREDICT_MODE(1), .CNT_WIDTH(4))
      dutB (.clk(clk), .rst(rst), .bus(busB));
   branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16), .PREDICT_MODE(0), .CNT_WIDTH(16))
      dutC (.clk(clk), .rst(rst), .bus(busC));

   typedef struct {
      logic [31:0] pc;
      logic        en;
      logic [31:0] updPc;
      logic        tk;
      logic [31:0] tgt;
      logic        pt;
      logic [31:0] ptg;
      logic        fl;
      logic        hit;
      logic        ptk;
      logic [31:0] nxt;
      logic        misp;
      int          bc;
      int          mc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [31:0] pc, input logic en, input logic [31:0] updPc,
                               input logic tk, input logic [31:0] tgt, input logic pt,
                               input logic [31:0] ptg, input logic fl, input logic hit,
                               input logic ptk, input logic [31:0] nxt, input logic misp,
                               input int bc, input int mc);
      vec_t v;
      v.pc = pc; v.en = en; v.updPc = updPc; v.tk = tk; v.tgt = tgt; v.pt = pt; v.ptg = ptg;
      v.fl = fl; v.hit = hit; v.ptk = ptk; v.nxt = nxt; v.misp = misp; v.bc = bc; v.mc = mc;
      return v;
   endfunction

   function automatic vec_t idle(input logic [31:0] pc, input logic hit, input logic ptk,
                                 input logic [31:0] nxt, input int bc, input int mc);
      return mk(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, hit, ptk, nxt, 1'b0, bc, mc);
   endfunction

   function automatic int sat15(input int x);
      return (x > 15) ? 15 : x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      busA.pc_f = v.pc;  busB.pc_f = v.pc;  busC.pc_f = v.pc;
      busA.upd_en = v.en;  busB.upd_en = v.en;  busC.upd_en = v.en;
      busA.upd_pc = v.updPc;  busB.upd_pc = v.updPc;  busC.upd_pc = v.updPc;
      busA.upd_taken = v.tk;  busB.upd_taken = v.tk;  busC.upd_taken = v.tk;
      busA.upd_target = v.tgt;  busB.upd_target = v.tgt;  busC.upd_target = v.tgt;
      busA.upd_pred_taken = v.pt;  busB.upd_pred_taken = v.pt;  busC.upd_pred_taken = v.pt;
      busA.upd_pred_target = v.ptg;  busB.upd_pred_target = v.ptg;  busC.upd_pred_target = v.ptg;
      busA.flush_all = v.fl;  busB.flush_all = v.fl;  busC.flush_all = v.fl;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t upd44;
      upd44 = mk(32'hC8, 1'b1, 32'h44, 1'b0, 32'h48, 1'b0, 32'h48, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 0, 0);

      // pc, en, updPc, taken, target, predTaken, predTarget, flush | hit, predTaken, next, misp, branchCnt, mispCnt
      vecs.push_back(idle(32'h40, 1'b0, 1'b0, 32'h44, 0, 0));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44,  1'b0, 1'b0, 1'b0, 32'h44,  1'b1, 0, 0));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1, 1));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 2, 1));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h44,  1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 3, 1));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h44,  1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 4, 2));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h44,  1'b0, 32'h44,  1'b0, 1'b1, 1'b0, 32'h44,  1'b0, 5, 3));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b0, 32'h44,  1'b0, 32'h44,  1'b0, 1'b1, 1'b0, 32'h44,  1'b0, 6, 3));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44,  1'b0, 1'b1, 1'b0, 32'h44,  1'b1, 7, 3));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h200, 1'b0, 32'h44,  1'b0, 1'b1, 1'b0, 32'h44,  1'b1, 8, 4));
      vecs.push_back(idle(32'h40, 1'b1, 1'b1, 32'h200, 9, 5));
      vecs.push_back(mk(32'h40, 1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 9, 5));
      vecs.push_back(idle(32'h80, 1'b0, 1'b0, 32'h84, 10, 6));
      vecs.push_back(mk(32'h80, 1'b1, 32'h80, 1'b1, 32'h500, 1'b0, 32'h84,  1'b0, 1'b0, 1'b0, 32'h84,  1'b1, 10, 6));
      vecs.push_back(idle(32'h40, 1'b0, 1'b0, 32'h44, 11, 7));
      vecs.push_back(idle(32'h80, 1'b1, 1'b1, 32'h500, 11, 7));
      vecs.push_back(mk(32'h1000, 1'b1, 32'h44, 1'b0, 32'h48, 1'b0, 32'h48, 1'b0, 1'b0, 1'b0, 32'h1004, 1'b0, 11, 7));
      vecs.push_back(idle(32'h44, 1'b0, 1'b0, 32'h48, 12, 7));
      vecs.push_back(idle(32'h82, 1'b1, 1'b1, 32'h500, 12, 7));
      vecs.push_back(mk(32'h80, 1'b1, 32'h44, 1'b1, 32'h600, 1'b0, 32'h48, 1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 12, 7));
      vecs.push_back(idle(32'h80, 1'b0, 1'b0, 32'h84, 13, 8));
      vecs.push_back(idle(32'h44, 1'b0, 1'b0, 32'h48, 13, 8));
      vecs.push_back(mk(32'hC8, 1'b1, 32'hC8, 1'b1, 32'h10, 1'b0, 32'hCC, 1'b0, 1'b0, 1'b0, 32'hCC, 1'b1, 13, 8));
      vecs.push_back(mk(32'hC8, 1'b1, 32'hC8, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 14, 9));
      vecs.push_back(mk(32'hC8, 1'b1, 32'hC8, 1'b0, 32'hCC, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 15, 9));

      drive(idle(32'h40, 1'b0, 1'b0, 32'h44, 0, 0));
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         drive(vecs[k]);
         #1;
         check($sformatf("v%0d A.hit", k),  {31'h0, busA.hit_f},        {31'h0, vecs[k].hit});
         check($sformatf("v%0d A.ptk", k),  {31'h0, busA.pred_taken_f}, {31'h0, vecs[k].ptk});
         check($sformatf("v%0d A.next", k), busA.next_pc_f,             vecs[k].nxt);
         check($sformatf("v%0d A.misp", k), {31'h0, busA.mispredict},   {31'h0, vecs[k].misp});
         check($sformatf("v%0d A.bcnt", k), {16'h0, busA.branch_cnt},     vecs[k].bc);
         check($sformatf("v%0d A.mcnt", k), {16'h0, busA.mispredict_cnt}, vecs[k].mc);
         check($sformatf("v%0d B.bcnt", k), {28'h0, busB.branch_cnt},     sat15(vecs[k].bc));
         check($sformatf("v%0d B.mcnt", k), {28'h0, busB.mispredict_cnt}, sat15(vecs[k].mc));
         check($sformatf("v%0d C.hit", k),  {31'h0, busC.hit_f},        32'h0);
         check($sformatf("v%0d C.next", k), busC.next_pc_f,             vecs[k].pc + 32'h4);
         check($sformatf("v%0d C.misp", k), {31'h0, busC.mispredict},   {31'h0, vecs[k].misp});
         check($sformatf("v%0d C.bcnt", k), {16'h0, busC.branch_cnt},   vecs[k].bc);
      end

      // Four more correctly predicted not-taken updates bring the total to 20.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(upd44);
      end
      @(negedge clk);
      drive(idle(32'hC8, 1'b1, 1'b1, 32'h10, 0, 0));
      #1;
      check("sat A.bcnt", {16'h0, busA.branch_cnt},     32'd20);
      check("sat A.mcnt", {16'h0, busA.mispredict_cnt}, 32'd10);
      check("sat B.bcnt", {28'h0, busB.branch_cnt},     32'd15);
      check("sat B.mcnt", {28'h0, busB.mispredict_cnt}, 32'd10);
      check("sat C.bcnt", {16'h0, busC.branch_cnt},     32'd20);
      check("pre-rst A.hit",  {31'h0, busA.hit_f}, 32'h1);
      check("pre-rst A.next", busA.next_pc_f,      32'h10);

      // Asynchronous reset mid-cycle, sampled before the next rising edge.
      #2;
      rst = 1'b0;
      #1;
      check("rst A.hit",  {31'h0, busA.hit_f},          32'h0);
      check("rst A.ptk",  {31'h0, busA.pred_taken_f},   32'h0);
      check("rst A.next", busA.next_pc_f,               32'hCC);
      check("rst A.bcnt", {16'h0, busA.branch_cnt},     32'h0);
      check("rst A.mcnt", {16'h0, busA.mispredict_cnt}, 32'h0);
      check("rst B.bcnt", {28'h0, busB.branch_cnt},     32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("post-rst A.hit", {31'h0, busA.hit_f}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
